// File: rtl/data_memory_sweep_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_sweep_if
// Description : Bus bundle for data_memory_sweep. It carries the write port,
//               the read port, the init-sweep control and the parity test
//               hook. The master side drives requests and the slave side is
//               the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_sweep_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              clr_req;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              inj_perr;
  logic              par_err;

  modport master (
    output clr_req, we, waddr, wdata, re, raddr, inj_perr,
    input  busy, rdata, rvalid, par_err
  );

  modport slave (
    input  clr_req, we, waddr, wdata, re, raddr, inj_perr,
    output busy, rdata, rvalid, par_err
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_sweep.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_sweep
// Description : Single-clock data memory with one write port and one read
//               port. Reads are registered and carry a valid strobe. A
//               same-address read during a write returns the new data
//               (write-first). An init sequencer writes INIT_VAL to every
//               word after reset or on clr_req, so the array itself has no
//               reset and can map to block RAM.
//               Optional macro DATA_MEM_PARITY_EN adds a stored even-parity
//               bit per word and a par_err flag on reads.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_sweep #(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  data_memory_sweep_if.slave   bus
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef DATA_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Storage array: no reset branch, so it can map to block RAM
  logic [MEM_W-1:0]  mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  init_word;
  logic [MEM_W-1:0]  user_word;

  logic              rd_fire;
  logic              rd_fwd;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

`ifdef DATA_MEM_PARITY_EN
  logic              par_err_q;

  // Parity bit sits above the data. The inject hook flips it on user writes only.
  assign init_word = {^INIT_VAL, INIT_VAL};
  assign user_word = {(^bus.wdata) ^ bus.inj_perr, bus.wdata};
  assign bus.par_err = par_err_q;
`else
  logic              unused_inj_perr;

  assign init_word       = INIT_VAL;
  assign user_word       = bus.wdata;
  assign unused_inj_perr = bus.inj_perr;
  assign bus.par_err     = 1'b0;
`endif

  // Reads and forwarding are accepted only in READY, and only when no clear request is present
  assign rd_fire = (state_q == ST_READY) && !bus.clr_req && bus.re;
  assign rd_fwd  = rd_fire && bus.we && (bus.waddr == bus.raddr);

  assign bus.busy   = (state_q == ST_INIT);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

  // State and sweep pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: the sweep walks the pointer to all-ones, which then wraps to 0
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (bus.clr_req) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Single write port, shared between the sweep and user writes, selected by state
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = init_word;
    if (state_q == ST_INIT) begin
      mem_we = 1'b1;
    end else if (!bus.clr_req && bus.we) begin
      mem_we    = 1'b1;
      mem_waddr = bus.waddr;
      mem_wdata = user_word;
    end
  end

  // Array write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port with write-first forwarding on address match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rvalid_q <= rd_fire;
      if (rd_fire) begin
        rdata_q <= rd_fwd ? bus.wdata : mem[bus.raddr][DATA_W-1:0];
      end
`ifdef DATA_MEM_PARITY_EN
      par_err_q <= rd_fire && !rd_fwd && (^mem[bus.raddr]);
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_sweep
// Description : Self-checking bench for data_memory_sweep (DATA_W=4,
//               ADDR_W=4, INIT_VAL=0). It applies a vector table for
//               write/read/forward/parity and hand-written sequences for
//               the reset sweep, clr_req and a reset during the sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_sweep;

  localparam int          DW = 4;
  localparam int          AW = 4;
  localparam logic [3:0]  IV = 4'd0;
`ifdef DATA_MEM_PARITY_EN
  localparam logic        PAR = 1'b1;
`else
  localparam logic        PAR = 1'b0;
`endif

  typedef struct {
    logic       we;
    logic [3:0] waddr;
    logic [3:0] wdata;
    logic       inj;
    logic       re;
    logic [3:0] raddr;
    logic       exp_rv;
    logic [3:0] exp_rd;
    logic       exp_pe;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_memory_sweep_if #(.DATA_W(DW), .ADDR_W(AW)) dif ();

  data_memory_sweep #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(IV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] wd,
                       input logic inj, input logic re, input logic [3:0] ra);
    dif.clr_req  = 1'b0;
    dif.we       = we;
    dif.waddr    = wa;
    dif.wdata    = wd;
    dif.inj_perr = inj;
    dif.re       = re;
    dif.raddr    = ra;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy drops. Optionally require rvalid=0 on each of them.
  task automatic sweep_count(output int n, input bit chk_rv);
    n = 0;
    do begin
      tick();
      n++;
      if (chk_rv) check("rvalid_during_sweep", 32'(dif.rvalid), 32'd0);
    end while (dif.busy === 1'b1 && n < 64);
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [3:0] wd,
                              input logic inj, input logic re, input logic [3:0] ra,
                              input logic rv, input logic [3:0] rd, input logic pe);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd; v.inj = inj;
    v.re = re; v.raddr = ra;
    v.exp_rv = rv; v.exp_rd = rd; v.exp_pe = pe;
    return v;
  endfunction

  vec_t vt [19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vt[0]  = mk(1, 4'd2, 4'd5, 0, 0, 4'd0, 0, 4'd0, 0);
    vt[1]  = mk(1, 4'd1, 4'd1, 0, 0, 4'd0, 0, 4'd0, 0);
    vt[2]  = mk(0, 4'd0, 4'd0, 0, 1, 4'd2, 1, 4'd5, 0);
    vt[3]  = mk(0, 4'd0, 4'd0, 0, 1, 4'd1, 1, 4'd1, 0);
    vt[4]  = mk(1, 4'd7, 4'd3, 0, 0, 4'd0, 0, 4'd0, 0);
    vt[5]  = mk(1, 4'd7, 4'd9, 0, 1, 4'd7, 1, 4'd9, 0);
    vt[6]  = mk(0, 4'd0, 4'd0, 0, 1, 4'd7, 1, 4'd9, 0);
    vt[7]  = mk(1, 4'd7, 4'd3, 0, 0, 4'd0, 0, 4'd0, 0);
    vt[8]  = mk(1, 4'd6, 4'd9, 0, 1, 4'd7, 1, 4'd3, 0);
    vt[9]  = mk(0, 4'd0, 4'd0, 0, 1, 4'd6, 1, 4'd9, 0);
    vt[10] = mk(1, 4'd3, 4'd6, 1, 0, 4'd0, 0, 4'd0, 0);
    vt[11] = mk(0, 4'd0, 4'd0, 0, 1, 4'd3, 1, 4'd6, PAR);
    vt[12] = mk(1, 4'd3, 4'd6, 0, 0, 4'd0, 0, 4'd0, 0);
    vt[13] = mk(0, 4'd0, 4'd0, 0, 1, 4'd3, 1, 4'd6, 0);
    vt[14] = mk(1, 4'd3, 4'd6, 1, 1, 4'd3, 1, 4'd6, 0);
    vt[15] = mk(0, 4'd0, 4'd0, 0, 1, 4'd3, 1, 4'd6, PAR);
    vt[16] = mk(1, 4'd5, 4'd2, 0, 1, 4'd3, 1, 4'd6, PAR);
    vt[17] = mk(0, 4'd0, 4'd0, 0, 1, 4'd5, 1, 4'd2, 0);
    vt[18] = mk(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0);

    // ---- Reset state and the first sweep
    idle();
    #2 rst = 1'b1;
    #1;
    check("rst_busy",    32'(dif.busy),    32'd1);
    check("rst_rvalid",  32'(dif.rvalid),  32'd0);
    check("rst_rdata",   32'(dif.rdata),   32'd0);
    check("rst_par_err", 32'(dif.par_err), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    sweep_count(n, 1'b1);
    check("sweep0_len", 32'(n), 32'd16);

    // ---- Fill with garbage, then reset and require a full clean sweep
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 4'(i) ^ 4'hB, 1'b0, 1'b0, 4'd0);
      tick();
    end
    idle();
    rst = 1'b1;
    #1;
    check("rst2_busy", 32'(dif.busy), 32'd1);
    tick();
    rst = 1'b0;
    sweep_count(n, 1'b1);
    check("sweep1_len", 32'(n), 32'd16);
    check("sweep1_busy_low", 32'(dif.busy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'(i));
      tick();
      check("init_rvalid", 32'(dif.rvalid), 32'd1);
      check("init_rdata",  32'(dif.rdata),  32'(IV));
    end

    // ---- Vector table
    for (int k = 0; k < 19; k++) begin
      drive(vt[k].we, vt[k].waddr, vt[k].wdata, vt[k].inj, vt[k].re, vt[k].raddr);
      tick();
      check($sformatf("vec%0d_rvalid", k), 32'(dif.rvalid), 32'(vt[k].exp_rv));
      check($sformatf("vec%0d_par_err", k), 32'(dif.par_err), 32'(vt[k].exp_pe));
      if (vt[k].exp_rv) begin
        check($sformatf("vec%0d_rdata", k), 32'(dif.rdata), 32'(vt[k].exp_rd));
      end
    end

    // ---- clr_req drops the same-cycle write and re-sweeps
    drive(1'b1, 4'd4, 4'd12, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4);
    tick();
    check("clr_pre_rdata", 32'(dif.rdata), 32'd12);
    drive(1'b1, 4'd4, 4'd8, 1'b0, 1'b1, 4'd4);
    dif.clr_req = 1'b1;
    tick();
    check("clr_busy",   32'(dif.busy),   32'd1);
    check("clr_rvalid", 32'(dif.rvalid), 32'd0);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4);
    sweep_count(n, 1'b1);
    check("clr_sweep_len", 32'(n), 32'd16);
    tick();
    check("clr_read_rvalid", 32'(dif.rvalid), 32'd1);
    check("clr_read_rdata",  32'(dif.rdata),  32'(IV));

    // ---- Reset in the middle of a sweep restarts it from zero
    idle();
    dif.clr_req = 1'b1;
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("abort_rvalid", 32'(dif.rvalid), 32'd0);
    end
    rst = 1'b1;
    #1;
    check("abort_busy",   32'(dif.busy),   32'd1);
    check("abort_rvalid", 32'(dif.rvalid), 32'd0);
    tick();
    rst = 1'b0;
    sweep_count(n, 1'b1);
    check("abort_sweep_len", 32'(n), 32'd16);
    tick();
    check("abort_read_rvalid", 32'(dif.rvalid), 32'd1);
    check("abort_read_rdata",  32'(dif.rdata),  32'(IV));
    idle();
    tick();
    check("final_rvalid", 32'(dif.rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
